// File: rtl/ps2_key_input.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_key_input: PS/2 receiver + set-2 decoder giving held jump/start levels |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ps2_key_input #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       jump,
    output logic       start,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int             c_FW       = $clog2(FILTER_LEN + 1);
    localparam int             c_TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FW-1:0] c_FILT_MAX = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_MAX   = c_TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic            r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic            r_fclk, r_fclk_d;
    logic [c_FW-1:0] r_filt_cnt;
    logic [c_TW-1:0] r_to_cnt;
    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [7:0]      r_scan_code;
    logic            r_code_valid, r_frame_err;
    logic            r_brk_pend, r_ext_pend;
    logic            r_sp_held, r_up_held, r_start, r_jump;

    logic w_strobe, w_timeout, w_stop_strobe, w_stop_ok, w_stop_bad;
    logic w_key_hit, w_sp_next, w_up_next, w_start_next;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_fclk     <= 1'b1;
            r_fclk_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
            r_fclk_d   <= r_fclk;
            // The FILTER_LEN-th consecutive differing sample flips fclk
            if (r_clk_sync == r_fclk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_MAX) begin
                r_fclk     <= r_clk_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_FW'(1);
            end
        end
    end

    assign w_strobe      = r_fclk_d & ~r_fclk;
    assign w_timeout     = (r_state != S_IDLE) && (r_to_cnt == c_TO_MAX);
    assign w_stop_strobe = (r_state == S_STOP) && w_strobe && !w_timeout;
    assign w_stop_ok     = w_stop_strobe && r_dat_sync && (^{r_shift, r_parity});
    assign w_stop_bad    = (w_stop_strobe && !w_stop_ok) || w_timeout;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_to_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_scan_code  <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == S_IDLE || w_strobe) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TW'(1);
            end
            if (w_timeout) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_strobe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_sync) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {r_dat_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= r_dat_sync;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        if (w_stop_ok) begin
                            r_code_valid <= 1'b1;
                            r_scan_code  <= r_shift;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Decode from the byte being accepted so levels move with code_valid
    always_comb begin
        w_key_hit    = w_stop_ok && (r_shift != 8'hF0) && (r_shift != 8'hE0);
        w_sp_next    = r_sp_held;
        w_up_next    = r_up_held;
        w_start_next = r_start;
        if (w_key_hit) begin
            if ({r_ext_pend, r_shift} == 9'h029) w_sp_next    = !r_brk_pend;
            if ({r_ext_pend, r_shift} == 9'h175) w_up_next    = !r_brk_pend;
            if ({r_ext_pend, r_shift} == 9'h05A) w_start_next = !r_brk_pend;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
            r_sp_held  <= 1'b0;
            r_up_held  <= 1'b0;
            r_start    <= 1'b0;
            r_jump     <= 1'b0;
        end else begin
            if (w_stop_bad) begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
            end else if (w_stop_ok) begin
                if (r_shift == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else begin
                    r_brk_pend <= 1'b0;
                    r_ext_pend <= 1'b0;
                end
            end
            r_sp_held <= w_sp_next;
            r_up_held <= w_up_next;
            r_start   <= w_start_next;
            r_jump    <= w_sp_next | w_up_next;
        end
    end

    assign jump       = r_jump;
    assign start      = r_start;
    assign scan_code  = r_scan_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_input.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_ps2_key_input: directed + random PS/2 frames against a key-state model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ps2_key_input;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 25;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       jump, start, code_valid, frame_err;
    logic [7:0] scan_code;

    ps2_key_input #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .jump(jump), .start(start), .scan_code(scan_code),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    // Pulse monitor
    int   nvalid = 0, nerr = 0, overlap = 0, dbl = 0;
    logic jump_at_valid = 1'b0, start_at_valid = 1'b0;
    logic prev_v = 1'b0, prev_e = 1'b0;
    always @(negedge sys_clk) begin
        if (code_valid) begin
            nvalid++;
            jump_at_valid  = jump;
            start_at_valid = start;
        end
        if (frame_err) nerr++;
        if (code_valid && frame_err) overlap++;
        if ((code_valid && prev_v) || (frame_err && prev_e)) dbl++;
        prev_v = code_valid;
        prev_e = frame_err;
    end

    // Reference model: set of held keys indexed by {extended, code}
    bit       pressed [512];
    bit       m_brk = 1'b0, m_ext = 1'b0;
    logic [7:0] m_code = 8'h00;

    function automatic logic exp_jump();
        return pressed[9'h029] | pressed[9'h175];
    endfunction

    function automatic logic exp_start();
        return pressed[9'h05A];
    endfunction

    task automatic model_reset();
        foreach (pressed[i]) pressed[i] = 1'b0;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hF0)      m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            pressed[(m_ext ? 256 : 0) + int'(b)] = !m_brk;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cycles(HALF);
        ps2_clk = 1'b0;
        cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic do_byte(input string tag, input logic [7:0] b, input bit bad_par);
        int nv0, ne0;
        nv0 = nvalid;
        ne0 = nerr;
        send_frame(b, bad_par);
        cycles(2 * HALF);
        if (bad_par) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else begin
            model_byte(b);
        end
        @(negedge sys_clk);
        check({tag, ".valid_cnt"}, 32'(nvalid - nv0), bad_par ? 32'd0 : 32'd1);
        check({tag, ".err_cnt"},   32'(nerr - ne0),   bad_par ? 32'd1 : 32'd0);
        check({tag, ".scan_code"}, 32'(scan_code), 32'(m_code));
        check({tag, ".jump"},      32'(jump),      32'(exp_jump()));
        check({tag, ".start"},     32'(start),     32'(exp_start()));
        if (!bad_par) begin
            check({tag, ".jump_at_valid"},  32'(jump_at_valid),  32'(exp_jump()));
            check({tag, ".start_at_valid"}, 32'(start_at_valid), 32'(exp_start()));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".jump"},       32'(jump),       32'd0);
        check({tag, ".start"},      32'(start),      32'd0);
        check({tag, ".scan_code"},  32'(scan_code),  32'd0);
        check({tag, ".code_valid"}, 32'(code_valid), 32'd0);
        check({tag, ".frame_err"},  32'(frame_err),  32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nv0, ne0;
        logic [7:0] tbl [10];
        logic [7:0] b;
        tbl = '{8'h29, 8'h75, 8'h5A, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00};
        model_reset();
        cycles(5);
        @(negedge sys_clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        cycles(10);

        // Space make/break
        do_byte("sp_make", 8'h29, 1'b0);
        do_byte("sp_f0",   8'hF0, 1'b0);
        do_byte("sp_brk",  8'h29, 1'b0);
        // Extended Up, then keypad 8
        do_byte("up_e0",   8'hE0, 1'b0);
        do_byte("up_make", 8'h75, 1'b0);
        do_byte("up_e0b",  8'hE0, 1'b0);
        do_byte("up_f0",   8'hF0, 1'b0);
        do_byte("up_brk",  8'h75, 1'b0);
        do_byte("kp8",     8'h75, 1'b0);
        // Overlap and Enter
        do_byte("ov_sp",   8'h29, 1'b0);
        do_byte("ov_e0",   8'hE0, 1'b0);
        do_byte("ov_up",   8'h75, 1'b0);
        do_byte("ov_sp_rep", 8'h29, 1'b0);
        do_byte("ov_f0",   8'hF0, 1'b0);
        do_byte("ov_spb",  8'h29, 1'b0);
        do_byte("ov_e0b",  8'hE0, 1'b0);
        do_byte("ov_f0b",  8'hF0, 1'b0);
        do_byte("ov_upb",  8'h75, 1'b0);
        do_byte("ent_make", 8'h5A, 1'b0);
        do_byte("ent_f0",  8'hF0, 1'b0);
        do_byte("ent_brk", 8'h5A, 1'b0);
        // Bad parity then good
        do_byte("badpar",  8'h5A, 1'b1);
        do_byte("goodpar", 8'h5A, 1'b0);

        // Timeout after 4 data bits
        nv0 = nvalid;
        ne0 = nerr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        cycles(TIMEOUT_CYCLES + 200);
        m_brk = 1'b0;
        m_ext = 1'b0;
        @(negedge sys_clk);
        check("timeout.err_cnt",   32'(nerr - ne0),   32'd1);
        check("timeout.valid_cnt", 32'(nvalid - nv0), 32'd0);
        check("timeout.start",     32'(start),        32'(exp_start()));
        do_byte("after_to_f0", 8'hF0, 1'b0);
        do_byte("after_to",    8'h5A, 1'b0);

        // Short clock glitch with data low must not start a frame
        nv0 = nvalid;
        ne0 = nerr;
        ps2_data = 1'b0;
        cycles(2);
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(5);
        ps2_data = 1'b1;
        cycles(TIMEOUT_CYCLES + 50);
        @(negedge sys_clk);
        check("glitch.err_cnt",   32'(nerr - ne0),   32'd0);
        check("glitch.valid_cnt", 32'(nvalid - nv0), 32'd0);
        do_byte("after_glitch", 8'h29, 1'b0);

        // Reset partway through an F0 frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        ps2_data = 1'b1;
        cycles(3);
        rst_n = 1'b0;
        cycles(3);
        @(negedge sys_clk);
        check_idle_outputs("midreset");
        model_reset();
        @(posedge sys_clk);
        rst_n = 1'b1;
        cycles(20);
        do_byte("post_reset_sp", 8'h29, 1'b0);

        // Random byte streams, occasionally corrupted
        for (int i = 0; i < 40; i++) begin
            b = tbl[$urandom_range(0, 9)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            do_byte("rand", b, ($urandom_range(0, 7) == 0));
        end

        check("pulse_overlap", 32'(overlap), 32'd0);
        check("pulse_width",   32'(dbl),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
